// File: rtl/lane_merge_pkg.sv
// Shared constants for the four-lane merge FIFO stage.
// Lane width, lane count, FIFO depth and lane index constants.
package lane_merge_pkg;

  localparam int LM_DATA_W    = 8;
  localparam int LM_NUM_LANES = 4;
  localparam int LM_DEPTH     = 4;
  localparam int LM_ADDR_W    = 2;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

endpackage

// File: rtl/lane_fifo.sv
// Single-clock synchronous FIFO for one byte lane.
// Ports: push/din in, pop/dout out, registered full/empty, count.
module lane_fifo
  import lane_merge_pkg::*;
#(
  parameter int DATA_W = LM_DATA_W,
  parameter int DEPTH  = LM_DEPTH,
  parameter int ADDR_W = LM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_n;
  logic              wr_en;
  logic              rd_en;

  // A full FIFO still accepts a write when its head leaves this cycle.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign dout  = mem[rd_ptr];

  always_comb begin
    count_n = count;
    unique case ({wr_en, rd_en})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= (count_n == CNT_MAX);
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/lane_merge_fifo4.sv
// Merges four buffered byte lanes into one valid/ready byte stream.
// Macro LANE_MERGE_STRICT_ORDER_EN: grant only lane rr (strict 0,1,2,3).
module lane_merge_fifo4
  import lane_merge_pkg::*;
#(
  parameter int DATA_W = LM_DATA_W,
  parameter int DEPTH  = LM_DEPTH,
  parameter int ADDR_W = LM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              validin0,
  input  logic              validin1,
  input  logic              validin2,
  input  logic              validin3,
  input  logic [DATA_W-1:0] datain0,
  input  logic [DATA_W-1:0] datain1,
  input  logic [DATA_W-1:0] datain2,
  input  logic [DATA_W-1:0] datain3,
  input  logic              out_ready,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        lane_out,
  output logic [3:0]        fifo_full,
  output logic [3:0]        fifo_empty,
  output logic [3:0]        overflow_err
);

  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(DEPTH);

  logic [3:0]        vin;
  logic [DATA_W-1:0] din  [4];
  logic [DATA_W-1:0] dout [4];
  logic [ADDR_W:0]   cnt  [4];
  logic [3:0]        pop;
  logic [3:0]        drop;
  logic [1:0]        rr;
  logic [1:0]        grant;
  logic              grant_vld;
  logic              load;

  assign vin    = {validin3, validin2, validin1, validin0};
  assign din[0] = datain0;
  assign din[1] = datain1;
  assign din[2] = datain2;
  assign din[3] = datain3;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    lane_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_fifo (
      .clk    (clk),
      .reset_L(reset_L),
      .push   (vin[i]),
      .pop    (pop[i]),
      .din    (din[i]),
      .dout   (dout[i]),
      .full   (fifo_full[i]),
      .empty  (fifo_empty[i]),
      .count  (cnt[i])
    );
    assign pop[i]  = load & grant_vld & (grant == 2'(i));
    assign drop[i] = vin[i] & (cnt[i] == CNT_MAX) & ~pop[i];
  end

  assign load = ~valid_out | out_ready;

`ifdef LANE_MERGE_STRICT_ORDER_EN
  always_comb begin
    grant     = rr;
    grant_vld = ~fifo_empty[rr];
  end
`else
  // Scan from rr+3 down to rr so the lane nearest rr wins.
  always_comb begin
    grant     = rr;
    grant_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (!fifo_empty[rr + 2'(k)]) begin
        grant     = rr + 2'(k);
        grant_vld = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rr           <= 2'd0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      lane_out     <= 2'd0;
      overflow_err <= 4'h0;
    end else begin
      overflow_err <= overflow_err | drop;
      if (load) begin
        valid_out <= grant_vld;
        if (grant_vld) begin
          data_out <= dout[grant];
          lane_out <= grant;
          rr       <= grant + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lane_merge_fifo4.sv
// Directed bench for lane_merge_fifo4 with an expected-output queue.
// Builds for either arbiter mode (LANE_MERGE_STRICT_ORDER_EN).
module tb_lane_merge_fifo4;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       validin0, validin1, validin2, validin3;
  logic [7:0] datain0, datain1, datain2, datain3;
  logic       out_ready;
  logic       valid_out;
  logic [7:0] data_out;
  logic [1:0] lane_out;
  logic [3:0] fifo_full;
  logic [3:0] fifo_empty;
  logic [3:0] overflow_err;

  int checks = 0;
  int errors = 0;
  logic [9:0] expq [$];

  always #5 clk = ~clk;

  lane_merge_fifo4 dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .validin0    (validin0),
    .validin1    (validin1),
    .validin2    (validin2),
    .validin3    (validin3),
    .datain0     (datain0),
    .datain1     (datain1),
    .datain2     (datain2),
    .datain3     (datain3),
    .out_ready   (out_ready),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .lane_out    (lane_out),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .overflow_err(overflow_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor: every accepted byte must match the queue head.
  always @(negedge clk) begin
    if (reset_L && valid_out && out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_out", {22'd0, lane_out, data_out}, 32'h3ff);
      end else begin
        logic [9:0] e;
        e = expq.pop_front();
        chk("out_data", {24'd0, data_out}, {24'd0, e[7:0]});
        chk("out_lane", {30'd0, lane_out}, {30'd0, e[9:8]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    validin0 = 0; validin1 = 0; validin2 = 0; validin3 = 0;
    datain0 = 0; datain1 = 0; datain2 = 0; datain3 = 0;
  endtask

  task automatic do_reset();
    idle_in();
    reset_L = 1'b0;
    expq.delete();
    tick();
    tick();
    reset_L = 1'b1;
    tick();
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (expq.size() == 0) break;
      tick();
    end
    tick();
    chk(tag, expq.size(), 0);
    chk({tag, "_vout"}, {31'd0, valid_out}, 0);
  endtask

  initial begin
    idle_in();
    out_ready = 1'b0;
    reset_L   = 1'b0;
    #12;
    chk("rst_vout", {31'd0, valid_out}, 0);
    chk("rst_data", {24'd0, data_out}, 0);
    chk("rst_empty", {28'd0, fifo_empty}, 32'hf);
    chk("rst_full", {28'd0, fifo_full}, 0);
    do_reset();

    // Single byte on lane 2
    out_ready = 1'b1;
    validin2 = 1; datain2 = 8'hA5;
`ifndef LANE_MERGE_STRICT_ORDER_EN
    expq.push_back({2'd2, 8'hA5});
`endif
    tick();
    idle_in();
    chk("t2_empty", {28'd0, fifo_empty}, 32'hb);
    tick();
`ifdef LANE_MERGE_STRICT_ORDER_EN
    chk("t2_strict_vout", {31'd0, valid_out}, 0);
    chk("t2_strict_empty", {28'd0, fifo_empty}, 32'hb);
`else
    chk("t2_vout", {31'd0, valid_out}, 1);
    chk("t2_data", {24'd0, data_out}, 32'ha5);
    chk("t2_lane", {30'd0, lane_out}, 2);
`endif
    drain("t2_drain");

    // All lanes in one cycle
    do_reset();
    out_ready = 1'b1;
    validin0 = 1; validin1 = 1; validin2 = 1; validin3 = 1;
    datain0 = 8'h10; datain1 = 8'h11; datain2 = 8'h12; datain3 = 8'h13;
    for (int i = 0; i < 4; i++)
      expq.push_back({2'(i), 8'h10 + 8'(i)});
    tick();
    idle_in();
    chk("t3_empty", {28'd0, fifo_empty}, 0);
    drain("t3_drain");

    // Backpressure and overflow on lane 0
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      validin0 = 1; datain0 = 8'h40 + 8'(i);
      expq.push_back({2'd0, 8'h40 + 8'(i)});
      tick();
    end
    chk("t4_full", {28'd0, fifo_full}, 32'h1);
    chk("t4_vout", {31'd0, valid_out}, 1);
    chk("t4_park", {24'd0, data_out}, 32'h40);
    chk("t4_ovf0", {28'd0, overflow_err}, 0);
    datain0 = 8'h45;
    tick();
    idle_in();
    chk("t4_ovf1", {28'd0, overflow_err}, 32'h1);
    drain("t4_drain");
    chk("t4_sticky", {28'd0, overflow_err}, 32'h1);
    chk("t4_empty", {28'd0, fifo_empty}, 32'hf);

    // Asynchronous reset in the middle of traffic
    out_ready = 1'b0;
    validin1 = 1; validin3 = 1; datain1 = 8'h71; datain3 = 8'h73;
    tick();
    tick();
    #2;
    reset_L = 1'b0;
    #1;
    chk("t1_vout", {31'd0, valid_out}, 0);
    chk("t1_data", {24'd0, data_out}, 0);
    chk("t1_lane", {30'd0, lane_out}, 0);
    chk("t1_full", {28'd0, fifo_full}, 0);
    chk("t1_empty", {28'd0, fifo_empty}, 32'hf);
    chk("t1_ovf", {28'd0, overflow_err}, 0);
    do_reset();
    chk("t1_empty_rel", {28'd0, fifo_empty}, 32'hf);

    // Push into a full lane 1 while it is popped
    out_ready = 1'b0;
    validin0 = 1; datain0 = 8'h50;
    expq.push_back({2'd0, 8'h50});
    tick();
    idle_in();
    for (int i = 1; i < 5; i++) begin
      validin1 = 1; datain1 = 8'h60 + 8'(i);
      expq.push_back({2'd1, 8'h60 + 8'(i)});
      tick();
    end
    chk("t5_full", {28'd0, fifo_full}, 32'h2);
    chk("t5_park", {24'd0, data_out}, 32'h50);
    out_ready = 1'b1;
    datain1 = 8'h65;
    expq.push_back({2'd1, 8'h65});
    tick();
    idle_in();
    chk("t5_full_kept", {28'd0, fifo_full}, 32'h2);
    chk("t5_ovf", {28'd0, overflow_err}, 0);
    drain("t5_drain");

    // Only lanes 1 and 3 active
    do_reset();
    out_ready = 1'b1;
    validin1 = 1; validin3 = 1; datain1 = 8'h1a; datain3 = 8'h3a;
`ifndef LANE_MERGE_STRICT_ORDER_EN
    expq.push_back({2'd1, 8'h1a});
    expq.push_back({2'd3, 8'h3a});
    expq.push_back({2'd1, 8'h1b});
    expq.push_back({2'd3, 8'h3b});
`endif
    tick();
    datain1 = 8'h1b; datain3 = 8'h3b;
    tick();
    idle_in();
`ifdef LANE_MERGE_STRICT_ORDER_EN
    for (int i = 0; i < 4; i++) tick();
    chk("t6_strict_vout", {31'd0, valid_out}, 0);
    chk("t6_strict_empty", {28'd0, fifo_empty}, 32'h5);
`else
    drain("t6_drain");
    chk("t6_empty", {28'd0, fifo_empty}, 32'hf);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
